// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the signed-overflow flag).
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: $clog2(WIDTH), but never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds ovf to the bundle).
//
// Handshake: start is honoured only in a cycle where ready=1 (capture happens on that
// edge); anything on start while ready=0 is dropped. done is a one-cycle pulse, and
// diff/bout/ovf stay stable from that pulse until the next one.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input ready, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output ready, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input ready, done, diff, bout);
    modport slave  (input start, a, b, bin, output ready, done, diff, bout);
`endif

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - br_in, with borrow out.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    assign d      = x ^ y ^ br_in;
    assign br_out = (~x & y) | (~(x ^ y) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per cycle, LSB first, result after WIDTH cycles.
// Optional feature macro: SERIAL_SUB_OVF_EN (registers a signed-overflow flag on ovf).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus,
    output state_t              state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_r;
    logic             br;
    logic             bout_r;
    logic             cell_d;
    logic             cell_br;
    logic             last;
    logic             ready_c;
    logic             done_c;

    full_subtractor_cell u_cell (
        .x      (a_sh[0]),
        .y      (b_sh[0]),
        .br_in  (br),
        .d      (cell_d),
        .br_out (cell_br)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // The new bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
    always_comb begin
        res_nxt             = res_sh >> 1;
        res_nxt[WIDTH-1]    = cell_d;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_c = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE:    ready_c = 1'b1;
            DONE:    done_c  = 1'b1;
            default: ;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sh   <= bus.a;
                    b_sh   <= bus.b;
                    br     <= bus.bin;
                    cnt    <= '0;
                    res_sh <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb  <= bus.a[WIDTH-1];
                    b_msb  <= bus.b[WIDTH-1];
`endif
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= cell_br;
                    res_sh <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    // Outputs only move on the final bit so they read stable throughout RUN.
                    if (last) begin
                        diff_r <= res_nxt;
                        bout_r <= cell_br;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r  <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_c;
    assign bus.done  = done_c;
    assign bus.diff  = diff_r;
    assign bus.bout  = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf   = ovf_r;
`endif
    assign state_dbg = state;

endmodule
